// File: rtl/dmem_responder.sv
// Load/store responder for the core's stall-capable memory stage: one request in flight,
// programmable wait states, lane-masked stores and sign/zero-extended loads with fault reporting.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int          IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] ADDR_LIMIT = 33'(4 * DEPTH_WORDS);
    localparam logic [3:0]  WAIT_INIT  = 4'(WAIT_CYCLES);
    localparam bit          NO_WAIT    = (WAIT_CYCLES == 0);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_next;
    logic [3:0]  cnt;
    logic        write_q;
    logic [31:0] addr_q, wdata_q;
    logic [2:0]  funct3_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        commit;
    logic        op_write;
    logic [31:0] op_addr, op_wdata;
    logic [2:0]  op_funct3;
    logic        fault;
    logic [IDX_W-1:0] idx;
    logic [31:0] word;
    logic [3:0]  be;
    logic [31:0] lanes;

    logic [31:0] mem [DEPTH_WORDS];

    function automatic logic is_fault(input logic wr, input logic [31:0] addr, input logic [2:0] f3);
        logic illegal, misaligned, out_of_range;
        illegal      = (f3 == 3'b011) || (f3[2:1] == 2'b11) || (wr && f3[2]);
        misaligned   = ((f3[1:0] == 2'b01) && addr[0]) || ((f3 == 3'b010) && (addr[1:0] != 2'b00));
        out_of_range = ({1'b0, addr} >= ADDR_LIMIT);
        return illegal || misaligned || out_of_range;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [1:0] off,
                                                input logic [2:0] f3);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (f3[1:0])
            2'b00:   return {{24{b[7] & ~f3[2]}}, b};
            2'b01:   return {{16{h[15] & ~f3[2]}}, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] byte_enable(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return 4'b0001 << off;
            2'b01:   return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wd);
        case (f3[1:0])
            2'b00:   return {4{wd[7:0]}};
            2'b01:   return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    // With zero wait states the access commits on the accept edge, so it must see the live request.
    always_comb begin
        op_write  = (state == IDLE) ? req_write  : write_q;
        op_addr   = (state == IDLE) ? req_addr   : addr_q;
        op_wdata  = (state == IDLE) ? req_wdata  : wdata_q;
        op_funct3 = (state == IDLE) ? req_funct3 : funct3_q;
    end

    assign fault = is_fault(op_write, op_addr, op_funct3);
    assign idx   = op_addr[IDX_W+1:2];
    assign word  = mem[idx];
    assign be    = byte_enable(op_funct3, op_addr[1:0]);
    assign lanes = store_lanes(op_funct3, op_wdata);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        commit     = 1'b0;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (NO_WAIT) begin
                        state_next = RESP;
                        commit     = 1'b1;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd1) begin
                    state_next = RESP;
                    commit     = 1'b1;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && req_valid) begin
            write_q  <= req_write;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            funct3_q <= req_funct3;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            if (state == IDLE && req_valid) cnt <= WAIT_INIT;
            else if (state == WAIT)         cnt <= cnt - 4'd1;
            if (commit) begin
                err_q   <= fault;
                rdata_q <= (fault || op_write) ? 32'd0 : load_extend(word, op_addr[1:0], op_funct3);
            end else if (state == RESP && rsp_ready) begin
                rdata_q <= 32'd0;
                err_q   <= 1'b0;
            end
        end
    end

    // Reset on the commit edge wins, so an uncommitted store is dropped.
    always_ff @(posedge clk) begin
        if (commit && !reset && op_write && !fault) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= lanes[8*i +: 8];
            end
        end
    end

    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: unit 0 runs with two wait states, unit 1 with none.
module tb_dmem_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic [1:0]       req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_err;
    logic [1:0][31:0] req_addr, req_wdata, rsp_rdata;
    logic [1:0][2:0]  req_funct3;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc [2];

    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_funct3(req_funct3[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_err(rsp_err[0])
    );

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_funct3(req_funct3[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_err(rsp_err[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input int u, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [2:0] f3, input bit hold);
        int guard;
        req_write[u]  = wr;
        req_addr[u]   = addr;
        req_wdata[u]  = wdata;
        req_funct3[u] = f3;
        req_valid[u]  = 1'b1;
        guard = 0;
        while (!req_ready[u] && guard < 50) begin
            tick();
            guard++;
        end
        check("accept ready", 32'(req_ready[u]), 32'd1);
        tick();
        acc_cyc[u] = cyc;
        if (!hold) req_valid[u] = 1'b0;
    endtask

    task automatic await_rsp(input int u, output int lat);
        lat = 1;
        while (!rsp_valid[u] && lat < 50) begin
            tick();
            lat++;
        end
    endtask

    task automatic op(input int u, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [2:0] f3, input logic [31:0] exp_d, input logic exp_e,
                      input int exp_lat, input string tag);
        int lat;
        rsp_ready[u] = 1'b1;
        accept(u, wr, addr, wdata, f3, 1'b0);
        await_rsp(u, lat);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " rdata"}, rsp_rdata[u], exp_d);
        check({tag, " err"}, 32'(rsp_err[u]), 32'(exp_e));
        tick();
    endtask

    initial begin
        int a, lat;
        reset      = 1'b1;
        req_valid  = '0;
        req_write  = '0;
        req_addr   = '0;
        req_wdata  = '0;
        req_funct3 = '0;
        rsp_ready  = '1;
        tick();
        tick();
        reset = 1'b0;
        check("reset req_ready", 32'(req_ready[0]), 32'd1);
        check("reset rsp_valid", 32'(rsp_valid[0]), 32'd0);
        check("reset rsp_rdata", rsp_rdata[0], 32'd0);
        check("reset rsp_err", 32'(rsp_err[0]), 32'd0);

        // Word round trip and request spacing
        op(0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0, 1'b0, 3, "sw 10");
        a = acc_cyc[0];
        op(0, 1'b0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0, 3, "lw 10");
        check("spacing w2", 32'(acc_cyc[0] - a), 32'd4);

        // Byte lanes and extension
        op(0, 1'b1, 32'h20, 32'h0,        3'b010, 32'h0, 1'b0, 3, "sw 20");
        op(0, 1'b1, 32'h23, 32'h80,       3'b000, 32'h0, 1'b0, 3, "sb 23");
        op(0, 1'b1, 32'h20, 32'hFFFE,     3'b001, 32'h0, 1'b0, 3, "sh 20");
        op(0, 1'b0, 32'h23, 32'h0, 3'b000, 32'hFFFFFF80, 1'b0, 3, "lb 23");
        op(0, 1'b0, 32'h23, 32'h0, 3'b100, 32'h00000080, 1'b0, 3, "lbu 23");
        op(0, 1'b0, 32'h20, 32'h0, 3'b001, 32'hFFFFFFFE, 1'b0, 3, "lh 20");
        op(0, 1'b0, 32'h20, 32'h0, 3'b101, 32'h0000FFFE, 1'b0, 3, "lhu 20");
        op(0, 1'b0, 32'h20, 32'h0, 3'b010, 32'h8000FFFE, 1'b0, 3, "lw 20");

        // Faults
        op(0, 1'b0, 32'h22,  32'h0,        3'b010, 32'h0, 1'b1, 3, "lw misaligned");
        op(0, 1'b1, 32'h21,  32'h1111,     3'b001, 32'h0, 1'b1, 3, "sh misaligned");
        op(0, 1'b0, 32'h400, 32'h0,        3'b010, 32'h0, 1'b1, 3, "lw range");
        op(0, 1'b1, 32'h20,  32'hFFFFFFFF, 3'b100, 32'h0, 1'b1, 3, "store f3 100");
        op(0, 1'b0, 32'h20,  32'h0,        3'b010, 32'h8000FFFE, 1'b0, 3, "lw 20 after faults");

        // Back-pressure with a second request held pending
        rsp_ready[0] = 1'b0;
        accept(0, 1'b0, 32'h10, 32'h0, 3'b010, 1'b1);
        req_addr[0] = 32'h20;
        await_rsp(0, lat);
        check("bp latency", 32'(lat), 32'd3);
        check("bp req_ready 0", 32'(req_ready[0]), 32'd0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("bp rsp_valid", 32'(rsp_valid[0]), 32'd1);
            check("bp rdata", rsp_rdata[0], 32'hDEADBEEF);
            check("bp req_ready", 32'(req_ready[0]), 32'd0);
        end
        rsp_ready[0] = 1'b1;
        tick();
        check("bp after handshake valid", 32'(rsp_valid[0]), 32'd0);
        check("bp after handshake ready", 32'(req_ready[0]), 32'd1);
        tick();
        req_valid[0] = 1'b0;
        check("bp second accepted", 32'(req_ready[0]), 32'd0);
        await_rsp(0, lat);
        check("bp second latency", 32'(lat), 32'd3);
        check("bp second rdata", rsp_rdata[0], 32'h8000FFFE);
        tick();

        // Reset during WAIT discards the store
        op(0, 1'b1, 32'h30, 32'hCAFEF00D, 3'b010, 32'h0, 1'b0, 3, "sw 30");
        accept(0, 1'b1, 32'h30, 32'h12345678, 3'b010, 1'b0);
        tick();
        check("mid-store still waiting", 32'(rsp_valid[0]), 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("post-reset req_ready", 32'(req_ready[0]), 32'd1);
        check("post-reset rsp_valid", 32'(rsp_valid[0]), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("no stale response", 32'(rsp_valid[0]), 32'd0);
        end
        op(0, 1'b0, 32'h30, 32'h0, 3'b010, 32'hCAFEF00D, 1'b0, 3, "lw 30 after reset");

        // Zero wait states
        op(1, 1'b1, 32'h40, 32'h0BADF00D, 3'b010, 32'h0, 1'b0, 1, "w0 sw 40");
        op(1, 1'b0, 32'h40, 32'h0, 3'b010, 32'h0BADF00D, 1'b0, 1, "w0 lw 40");
        a = acc_cyc[1];
        op(1, 1'b0, 32'h40, 32'h0, 3'b000, 32'h0000000D, 1'b0, 1, "w0 lb 40");
        check("w0 spacing 1", 32'(acc_cyc[1] - a), 32'd2);
        a = acc_cyc[1];
        op(1, 1'b0, 32'h42, 32'h0, 3'b001, 32'h00000BAD, 1'b0, 1, "w0 lh 42");
        check("w0 spacing 2", 32'(acc_cyc[1] - a), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
